// File: rtl/operand_fetch_stage.sv
// Operand fetch: scoreboard hazard check, regfile read with writeback
// bypass, and a single output pipeline register toward execute.
module operand_fetch_stage #(
  parameter int DW  = 16,
  parameter int AW  = 5,
  parameter int OPW = 6,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [AW-1:0]  in_rd,
  input  logic           in_we,
  input  logic [AW-1:0]  in_rs1,
  input  logic [AW-1:0]  in_rs2,
  input  logic           in_rs1_en,
  input  logic           in_rs2_en,
  output logic [AW-1:0]  rf_rs1_addr,
  output logic [AW-1:0]  rf_rs2_addr,
  input  logic [DW-1:0]  rf_rs1_data,
  input  logic [DW-1:0]  rf_rs2_data,
  input  logic           wb_valid,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [AW-1:0]  out_rd,
  output logic           out_we,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [CW-1:0]  stall_cnt
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] pending;
  logic [NR-1:0] pending_nxt;
  logic          clr1;
  logic          clr2;
  logic          clrd;
  logic          busy1;
  logic          busy2;
  logic          busyd;
  logic          haz;
  logic          space;
  logic          acc;

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;

  // A same-cycle writeback retires the hazard and supplies the operand
  assign clr1  = wb_valid && (wb_addr == in_rs1);
  assign clr2  = wb_valid && (wb_addr == in_rs2);
  assign clrd  = wb_valid && (wb_addr == in_rd);
  assign busy1 = pending[in_rs1] && !clr1;
  assign busy2 = pending[in_rs2] && !clr2;
  assign busyd = pending[in_rd] && !clrd;

  assign haz = in_valid && ((in_rs1_en && busy1) ||
                            (in_rs2_en && busy2) ||
                            (in_we && busyd));

  assign space    = !out_valid || out_ready;
  assign in_ready = space && !haz && !flush;
  assign acc      = in_valid && in_ready;

  // Later updates override earlier ones, so a new writer's set wins
  always_comb begin
    pending_nxt = pending;
    if (wb_valid)
      pending_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && out_we)
      pending_nxt[out_rd] = 1'b0;
    if (acc && in_we)
      pending_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_we    <= in_we;
      out_a     <= clr1 ? wb_data : rf_rs1_data;
      out_b     <= clr2 ? wb_data : rf_rs2_data;
    end else if (flush || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (haz && (stall_cnt != {CW{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Issue/operand-fetch stage directly upstream of the 32x16 register file.
- Takes decoded instruction fields over a valid/ready handshake and drives the register-file read addresses.
- Captures the 16-bit operands into an output pipeline register for the execute stage.
- Tracks outstanding writes with a 32-bit scoreboard, stalls on RAW/WAW hazards, and bypasses same-cycle writeback data.

Parameters:
- DW, 16, operand/data width (matches register file).
- AW, 5, register address width (32 registers).
- OPW, 6, opaque opcode/control width passed through unchanged.
- CW, 16, stall counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- in_op  input  OPW  opcode/control, passed through.
- in_rd  input  AW  destination register.
- in_we  input  1  instruction writes in_rd.
- in_rs1, in_rs2  input  AW  source registers.
- in_rs1_en, in_rs2_en  input  1  source actually used.
- rf_rs1_addr, rf_rs2_addr  output  AW  register-file read addresses; combinational copies of in_rs1/in_rs2.
- rf_rs1_data, rf_rs2_data  input  DW  register-file read data (combinational read).
- wb_valid  input  1  writeback this cycle; same signal driving the register file's write enable.
- wb_addr  input  AW  writeback register.
- wb_data  input  DW  writeback value.
- flush  input  1  synchronous kill of the held output instruction.
- out_valid  output  1  operands valid.
- out_ready  input  1  execute stage accepts.
- out_op  output  OPW  registered in_op.
- out_rd  output  AW  registered in_rd.
- out_we  output  1  registered in_we.
- out_a, out_b  output  DW  registered operands.
- stall_cnt  output  CW  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst_n low, async): pending[31:0]=0; out_valid=0; out_op/out_rd/out_a/out_b=0; out_we=0; stall_cnt=0.
- clr(r) = wb_valid && wb_addr==r.
- busy(r) = pending[r] && !clr(r).
- Hazard:
  - haz = in_valid && ((in_rs1_en && busy(in_rs1)) || (in_rs2_en && busy(in_rs2)) || (in_we && busy(in_rd))).
  - Disabled sources never stall.
  - The WAW check prevents two in-flight writers to the same register.
- Space: space = !out_valid || out_ready.
- Ready: in_ready = space && !haz && !flush. Purely combinational; may depend on in_valid and fields.
- Accept: acc = in_valid && in_ready.
  - On acc, the output register loads op/rd/we, and out_valid=1.
  - out_a = clr(in_rs1) ? wb_data : rf_rs1_data (bypass). out_b likewise for in_rs2.
  - Operands of disabled sources are still loaded per the same rule; their value is don't-care.
- Drain: if out_valid && out_ready && !acc, then out_valid <= 0. Data registers hold their value.
- Latency: one cycle from accept to out_valid. Throughput is one instruction per cycle with no hazards and out_ready=1.
- Scoreboard update per cycle, in this order:
  1. clear pending[wb_addr] if wb_valid;
  2. clear pending[out_rd] if flush && out_valid && out_we;
  3. set pending[in_rd] if acc && in_we.
  - Set wins over clear on the same address in the same cycle.
  - wb_valid to a non-pending address is harmless: no error, bit stays 0.
- Flush: out_valid <= 0 next edge; the held instruction's pending bit is released; no accept in the flush cycle. Flush with out_valid=0 has no effect.
- stall_cnt: increments by 1 each cycle in_valid && haz, saturating at all-ones. Never wraps; cleared only by reset.
- Backpressure: out_valid=1 && out_ready=0 holds all out_* stable. in_ready=0 regardless of hazard status; stall_cnt still counts only haz cycles.
- Reset mid-operation: all state cleared immediately, including in-flight pending bits. Downstream writebacks arriving after reset only clear already-zero bits.

Test Plan:
- Reset then idle: rst_n=0 with out_valid previously 1 -> out_valid=0, pending=0, stall_cnt=0 immediately, before any clock edge.
- Back-to-back independent ops: issue (rd=1,rs1=2,rs2=3), then (rd=4,rs1=5,rs2=6) with rf data 0x1111/0x2222, out_ready=1 -> in_ready held 1; outputs appear 1 cycle later in order; pending bits 1 and 4 set.
- RAW stall + bypass: after issuing rd=7, present rs1=7 -> in_ready=0, stall_cnt counts 3 cycles. Then wb_valid=1, wb_addr=7, wb_data=0xBEEF the same cycle as retry -> accepted, out_a=0xBEEF, pending[7]=0.
- WAW + simultaneous set/clear: rd=9 pending, new in_rd=9 with wb_addr=9 in the same cycle -> accepted, pending[9] remains 1.
- Backpressure and flush: out_valid=1, out_ready=0 for 4 cycles -> out_* stable, in_ready=0. Then flush with out_we=1, out_rd=12 -> out_valid=0 and pending[12]=0 next cycle.
- Saturation: force a hazard with CW=4 for 20 cycles -> stall_cnt stops at 15.
